// File: rtl/clksw_seq_pkg.sv
// Shared clock-control definitions: sequencer state encoding, default
// parameter values and the counter-width helper used by the clock-switch block.
package clksw_seq_pkg;

   typedef enum logic [1:0] {
      LS    = 2'd0,
      TO_HS = 2'd1,
      HS    = 2'd2,
      TO_LS = 2'd3
   } clk_state_e;

   localparam int unsigned DEF_SYNC_STAGES = 2;
   localparam int unsigned DEF_LS_HOLD     = 16;
   localparam int unsigned DEF_TIMEOUT     = 1023;

   // Bits needed to hold values 0..max_val, i.e. ceil(log2(max_val+1)), minimum 1.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      int unsigned w;
      w = 1;
      while ((w < 32) && ((max_val >> w) != 0)) w++;
      return w;
   endfunction

endpackage

// File: rtl/clksw_seq_sync_ff.sv
// N-stage synchroniser for an asynchronous level; reset value is a parameter so
// an acknowledge can come out of reset in its idle polarity.
module sync_ff #(
   parameter int unsigned STAGES  = 2,
   parameter logic        RST_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   // Shift the raw level through the flop chain; the last stage is the safe copy.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) sync_q <= {STAGES{RST_VAL}};
      else         sync_q <= {sync_q[STAGES-2:0], d_i};
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/clksw_seq.sv
// Clock-switch sequencer: requests the high-speed CPU clock when the host is idle,
// drops back to the host clock for host accesses, and stalls the CPU while the
// clock switch is mid-handshake. Stuck handshakes are abandoned after TIMEOUT.
module clksw_seq
   import clksw_seq_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int unsigned LS_HOLD     = DEF_LS_HOLD,
   parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
   input  logic hsclk_in,
   input  logic rst_b,
   input  logic req_valid,
   input  logic req_host,
   input  logic hs_allowed,
   input  logic hsclk_selected_in,
   input  logic lsclk_selected_in,
   input  logic err_clr,
   output logic hsclk_sel,
   output logic cpu_stall,
   output logic in_hs,
   output logic switch_err
);

   localparam int unsigned TMO_W  = cnt_width(TIMEOUT);
   localparam int unsigned HOLD_W = cnt_width(LS_HOLD);
   localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(TIMEOUT);
   localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(LS_HOLD);

   clk_state_e        state_q, state_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              err_q, err_d, err_set;
   logic              hsclk_sel_q, in_hs_q;
   logic              hs_ack, ls_ack;
   logic              host_req;

   assign host_req = req_valid & req_host;

   // The high-speed ack idles low and the host-clock ack idles high after reset.
   sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_hs_sync (
      .clk_i  (hsclk_in),
      .rst_ni (rst_b),
      .d_i    (hsclk_selected_in),
      .q_o    (hs_ack)
   );

   sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ls_sync (
      .clk_i  (hsclk_in),
      .rst_ni (rst_b),
      .d_i    (lsclk_selected_in),
      .q_o    (ls_ack)
   );

   // Next-state, dwell counter, handshake timeout and error-flag decisions.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      err_set = 1'b0;
      case (state_q)
         LS: begin
            if (host_req)            hold_d = HOLD_INIT;
            else if (hold_q != '0)   hold_d = hold_q - HOLD_W'(1);
            if ((hold_q == '0) && hs_allowed && !err_q && !host_req) state_d = TO_HS;
         end
         TO_HS: begin
            // A host request here is ignored: HS is entered first and left next cycle.
            if (hs_ack && !ls_ack) state_d = HS;
            else if (tmo_q == TMO_MAX) begin
               err_set = 1'b1;
               state_d = TO_LS;
            end
            else if (!hs_allowed) state_d = TO_LS;
         end
         HS: begin
            if (host_req || !hs_allowed) state_d = TO_LS;
         end
         TO_LS: begin
            if (ls_ack && !hs_ack) begin
               state_d = LS;
               hold_d  = HOLD_INIT;
            end
            else if (tmo_q == TMO_MAX) begin
               err_set = 1'b1;
               state_d = LS;
               hold_d  = HOLD_INIT;
            end
         end
         default: state_d = LS;
      endcase

      if (state_d != state_q)                          tmo_d = '0;
      else if ((state_q == TO_HS) || (state_q == TO_LS)) tmo_d = tmo_q + TMO_W'(1);
      else                                             tmo_d = '0;

      // A new timeout beats a simultaneous clear so the fault is never lost.
      if (err_set)      err_d = 1'b1;
      else if (err_clr) err_d = 1'b0;
      else              err_d = err_q;
   end

   // State register with outputs decoded from the next state on the same edge.
   always_ff @(posedge hsclk_in or negedge rst_b) begin
      if (!rst_b) begin
         state_q     <= LS;
         hold_q      <= HOLD_INIT;
         tmo_q       <= '0;
         err_q       <= 1'b0;
         hsclk_sel_q <= 1'b0;
         in_hs_q     <= 1'b0;
      end
      else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         tmo_q       <= tmo_d;
         err_q       <= err_d;
         hsclk_sel_q <= (state_d == TO_HS) || (state_d == HS);
         in_hs_q     <= (state_d == HS);
      end
   end

   assign hsclk_sel  = hsclk_sel_q;
   assign in_hs      = in_hs_q;
   assign switch_err = err_q;
   assign cpu_stall  = (state_q == TO_HS) || (state_q == TO_LS) ||
                       ((state_q == HS) && host_req);

endmodule

// File: tb/tb_clksw_seq.sv
// Directed bench for clksw_seq with a clock-switch model that acknowledges
// three cycles after hsclk_sel changes, or never (dead model).
module tb_clksw_seq;

   logic clk = 1'b0;
   logic rst_b = 1'b0;
   logic req_valid = 1'b0;
   logic req_host = 1'b0;
   logic hs_allowed = 1'b1;
   logic err_clr = 1'b0;
   logic ack_dead = 1'b0;
   logic hsclk_selected_in, lsclk_selected_in;
   logic hsclk_sel, cpu_stall, in_hs, switch_err;
   logic [2:0] sel_dly = 3'b000;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // Clock-switch model: acks follow hsclk_sel with a three-cycle delay.
   always @(posedge clk) sel_dly <= {sel_dly[1:0], hsclk_sel};
   assign hsclk_selected_in = ack_dead ? 1'b0 : sel_dly[2];
   assign lsclk_selected_in = ack_dead ? 1'b1 : ~sel_dly[2];

   clksw_seq dut (
      .hsclk_in          (clk),
      .rst_b             (rst_b),
      .req_valid         (req_valid),
      .req_host          (req_host),
      .hs_allowed        (hs_allowed),
      .hsclk_selected_in (hsclk_selected_in),
      .lsclk_selected_in (lsclk_selected_in),
      .err_clr           (err_clr),
      .hsclk_sel         (hsclk_sel),
      .cpu_stall         (cpu_stall),
      .in_hs             (in_hs),
      .switch_err        (switch_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
      else begin
         $display("ok   %s = %0d", tag, got);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int to_hs_n;
      int hs_n;
      logic stall_bad;
      logic left_ls;

      // Reset state
      #12;
      check("rst_hsclk_sel", hsclk_sel, 0);
      check("rst_in_hs", in_hs, 0);
      check("rst_cpu_stall", cpu_stall, 0);
      check("rst_switch_err", switch_err, 0);

      // Power-up: hold=16 expires after 16 edges, TO_HS on edge 17,
      // acks synchronised by edge 22, HS on edge 23.
      @(negedge clk);
      rst_b = 1'b1;
      to_hs_n = 0;
      hs_n = 0;
      stall_bad = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         tick(1);
         if (hsclk_sel && to_hs_n == 0) to_hs_n = i;
         if (in_hs && hs_n == 0) hs_n = i;
         if (cpu_stall !== (hsclk_sel && !in_hs)) stall_bad = 1'b1;
      end
      check("pwrup_to_hs_edge", to_hs_n, 17);
      check("pwrup_in_hs_edge", hs_n, 23);
      check("pwrup_stall_only_to_hs", stall_bad, 0);

      // Host request in HS: immediate stall, sel drops next edge, LS after acks.
      req_valid = 1'b1;
      req_host = 1'b1;
      #1;
      check("hsreq_stall_same_cycle", cpu_stall, 1);
      tick(1);
      check("hsreq_sel_next_edge", hsclk_sel, 0);
      check("hsreq_in_hs_next_edge", in_hs, 0);
      n = 1;
      while (cpu_stall && n < 50) begin
         tick(1);
         n++;
      end
      check("hsreq_stall_release_edge", n, 7);
      check("hsreq_ls_reached", hsclk_sel, 0);
      // The held access completes in LS and reloads the dwell counter.
      tick(1);
      req_valid = 1'b0;
      req_host = 1'b0;

      // Host requests every 10 cycles keep the block in LS.
      left_ls = 1'b0;
      for (int k = 0; k < 5; k++) begin
         for (int j = 0; j < 9; j++) begin
            tick(1);
            if (hsclk_sel) left_ls = 1'b1;
         end
         req_valid = 1'b1;
         req_host = 1'b1;
         tick(1);
         req_valid = 1'b0;
         req_host = 1'b0;
         if (hsclk_sel) left_ls = 1'b1;
      end
      check("periodic_stays_ls", left_ls, 0);
      n = 0;
      while (!hsclk_sel && n < 40) begin
         tick(1);
         n++;
      end
      check("periodic_to_hs_after_16_idle", n, 17);
      n = 0;
      while (!in_hs && n < 40) begin
         tick(1);
         n++;
      end
      check("periodic_reaches_hs", in_hs, 1);

      // hs_allowed drops in HS.
      hs_allowed = 1'b0;
      tick(1);
      check("hsoff_hs_sel", hsclk_sel, 0);
      check("hsoff_hs_stall", cpu_stall, 1);
      tick(30);
      check("hsoff_held_ls_sel", hsclk_sel, 0);
      check("hsoff_held_ls_stall", cpu_stall, 0);
      hs_allowed = 1'b1;
      tick(1);
      check("hson_to_hs", hsclk_sel, 1);
      // hs_allowed drops in TO_HS.
      hs_allowed = 1'b0;
      tick(1);
      check("hsoff_tohs_sel", hsclk_sel, 0);
      check("hsoff_tohs_stall", cpu_stall, 1);
      n = 0;
      while (cpu_stall && n < 40) begin
         tick(1);
         n++;
      end
      check("hsoff_tohs_back_ls", cpu_stall, 0);
      hs_allowed = 1'b1;
      n = 0;
      while (!in_hs && n < 60) begin
         tick(1);
         n++;
      end
      check("hson_reaches_hs", in_hs, 1);

      // Reset asserted in TO_LS, between clock edges.
      req_valid = 1'b1;
      req_host = 1'b1;
      tick(1);
      check("midrst_in_to_ls_stall", cpu_stall, 1);
      #2;
      rst_b = 1'b0;
      ack_dead = 1'b1;
      req_valid = 1'b0;
      req_host = 1'b0;
      #1;
      check("midrst_hsclk_sel", hsclk_sel, 0);
      check("midrst_in_hs", in_hs, 0);
      check("midrst_cpu_stall", cpu_stall, 0);
      check("midrst_switch_err", switch_err, 0);

      // Dead ack model: TO_HS at edge 17, timeout count reaches 1023 after edge 1040,
      // error and TO_LS on edge 1041, LS on edge 1042.
      tick(3);
      @(negedge clk);
      rst_b = 1'b1;
      tick(1040);
      check("dead_pre_timeout_err", switch_err, 0);
      check("dead_pre_timeout_sel", hsclk_sel, 1);
      tick(1);
      check("dead_timeout_err", switch_err, 1);
      check("dead_timeout_to_ls_sel", hsclk_sel, 0);
      check("dead_timeout_to_ls_stall", cpu_stall, 1);
      tick(1);
      check("dead_ls_stall", cpu_stall, 0);
      tick(40);
      check("dead_ls_held_sel", hsclk_sel, 0);
      check("dead_ls_held_err", switch_err, 1);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      check("errclr_clears", switch_err, 0);
      check("errclr_still_ls", hsclk_sel, 0);
      tick(1);
      check("errclr_reenter_to_hs", hsclk_sel, 1);
      tick(1023);
      check("second_pre_timeout_err", switch_err, 0);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      check("set_beats_clr_err", switch_err, 1);
      check("set_beats_clr_sel", hsclk_sel, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/clksw_seq.md
CLKSW_SEQ -- requirements
Module: clksw_seq

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, giving the number of synchroniser flops per acknowledge input (minimum 2).
REQ-002 The block SHALL have parameter LS_HOLD, default 16, giving the number of hsclk_in cycles to dwell in low speed after the last host access.
REQ-003 The block SHALL have parameter TIMEOUT, default 1023, giving the maximum hsclk_in cycles permitted in a transition state.
REQ-004 The block SHALL have port hsclk_in, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst_b, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port req_valid, input, 1 bit: the CPU presents an access this cycle.
REQ-007 The block SHALL have port req_host, input, 1 bit: the access targets the host (needs low-speed clock); it is qualified by req_valid.
REQ-008 The block SHALL have port hs_allowed, input, 1 bit: global high-speed enable; 0 forces low speed.
REQ-009 The block SHALL have port hsclk_selected_in, input, 1 bit: asynchronous acknowledge from the clock switch that the high-speed clock is driving the CPU.
REQ-010 The block SHALL have port lsclk_selected_in, input, 1 bit: asynchronous acknowledge from the clock switch that the host clock is driving the CPU.
REQ-011 The block SHALL have port err_clr, input, 1 bit: clears switch_err.
REQ-012 The block SHALL have port hsclk_sel, output, 1 bit: registered clock-select request to the clock switch.
REQ-013 The block SHALL have port cpu_stall, output, 1 bit: holds the CPU (deasserts RDY).
REQ-014 The block SHALL have port in_hs, output, 1 bit: high speed confirmed.
REQ-015 The block SHALL have port switch_err, output, 1 bit: sticky handshake timeout flag.

Function
REQ-016 Both acknowledge inputs SHALL pass through SYNC_STAGES-flop synchronisers (hs_ack, ls_ack), and only synchronised values SHALL be used.
REQ-017 The FSM SHALL have exactly four states: LS, TO_HS, HS, TO_LS.
REQ-018 hsclk_sel SHALL be a flop equal to 1 exactly when the state is TO_HS or HS.
REQ-019 in_hs SHALL be 1 exactly when the state is HS.
REQ-020 cpu_stall SHALL be combinational: 1 when the state is TO_HS or TO_LS, or when the state is HS and req_valid&req_host is high.
REQ-021 In LS, the hold counter SHALL load LS_HOLD on req_valid&req_host and otherwise decrement, saturating at 0.
REQ-022 LS SHALL go to TO_HS when hold==0, hs_allowed=1, switch_err=0, and req_valid&req_host=0.
REQ-023 TO_HS SHALL go to HS when hs_ack=1 and ls_ack=0.
REQ-024 TO_HS SHALL go to TO_LS when hs_allowed=0 (abort).
REQ-025 HS SHALL go to TO_LS when req_valid&req_host=1 or hs_allowed=0.
REQ-026 TO_LS SHALL go to LS when ls_ack=1 and hs_ack=0, and SHALL load hold=LS_HOLD on that transition.
REQ-027 A timeout counter sized to ceil(log2(TIMEOUT+1)) bits SHALL clear on every state entry and increment in TO_HS and TO_LS.
REQ-028 When the timeout counter reaches TIMEOUT in TO_HS, the block SHALL set switch_err and go to TO_LS.
REQ-029 When the timeout counter reaches TIMEOUT in TO_LS, the block SHALL set switch_err and go to LS.
REQ-030 switch_err SHALL clear on err_clr, and set SHALL win over a simultaneous err_clr.
REQ-031 While switch_err=1, LS SHALL NOT leave.
REQ-032 A host request arriving in TO_HS SHALL stay stalled, complete the HS entry, then take the HS to TO_LS transition on the next cycle.
REQ-033 All transitions SHALL take effect on the clock edge following their condition; the latency from the state change to the hsclk_sel change SHALL be 0 cycles (same flop edge).

Reset
REQ-034 On rst_b=0, the block SHALL asynchronously set: state=LS, hsclk_sel=0, in_hs=0, switch_err=0, hold=LS_HOLD, timeout=0.
REQ-035 On rst_b=0, the hs_ack synchronisers SHALL reset to 0 and the ls_ack synchronisers to 1.
REQ-036 cpu_stall SHALL be 0 during reset.
REQ-037 Reset asserted mid-transition SHALL abandon the handshake immediately.

Structure
REQ-038 State encodings, default parameter values, and the timeout-width function SHALL live in a shared clock package reused by the clock-switch block.
REQ-039 One sub-module, sync_ff (an N-stage synchroniser with a reset-value parameter), SHALL be instantiated twice.

Verification
REQ-040 The bench SHALL cover reset release with an ack model responding 3 cycles after hsclk_sel changes, no requests -> TO_HS at cycle 16, in_hs=1 at about cycle 21, and no stall outside TO_HS.
REQ-041 The bench SHALL cover a host request in HS -> cpu_stall=1 in the same cycle, hsclk_sel=0 on the next edge, LS reached after ack, stall released, and hold=16.
REQ-042 The bench SHALL cover host requests every 10 cycles in LS -> the block never leaves LS; after the last request it enters TO_HS exactly 16 idle cycles later.
REQ-043 The bench SHALL cover a dead ack model -> switch_err=1 at timeout count 1023 in TO_HS, TO_LS entered, LS held; err_clr then allows re-entry, and err_clr coincident with a new timeout leaves switch_err=1.
REQ-044 The bench SHALL cover hs_allowed dropping in TO_HS and in HS -> TO_LS on the next edge with hsclk_sel=0.
REQ-045 The bench SHALL cover rst_b asserted in TO_LS -> all outputs reach reset values without a clock edge.
